// File: rtl/gf_dsm_ctrl.sv
// gf_dsm_ctrl: sequencer for a digit-serial systolic GF(2^M) multiplier array.
// It latches one operand pair per accepted start, holds A on a_op and streams
// B into the array one D-bit digit per cycle, MSB digit first. It then waits
// LAT cycles for the array/delay line and captures array_res into result,
// pulsing done in the same cycle.
//
// Handshake: start is a request level that is sampled only while idle
// (busy=0). No ready is returned, so busy=0 is the acceptance window. A start
// seen while busy=1, including the DONE cycle, is dropped. abort cancels the
// operation in flight on the next edge and wins over start and over capture.
// Every output is a register, so outputs change only on a clock edge or on
// reset.
module gf_dsm_ctrl #(
  parameter int M   = 16,
  parameter int D   = 4,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [1:M]   a_in,
  input  logic [1:M]   b_in,
  input  logic [1:M]   array_res,
  output logic         busy,
  output logic [1:M]   a_op,
  output logic [1:D]   digit,
  output logic         digit_vld,
  output logic         first_dig,
  output logic [1:M]   result,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam int NDIG = M / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int LW   = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:M]    b_sr;   // digits of B that have not been presented yet, MSB-aligned
  logic [CW-1:0] dcnt;   // index of the digit currently on the digit output
  logic [LW-1:0] lcnt;   // drain cycles already spent

  assign dbg_state = state;

  // Sequencer state, counters and every registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      b_sr      <= '0;
      dcnt      <= '0;
      lcnt      <= '0;
      busy      <= 1'b0;
      a_op      <= '0;
      digit     <= '0;
      digit_vld <= 1'b0;
      first_dig <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            // Digit 0 goes out straight away; the rest waits in b_sr.
            a_op      <= a_in;
            digit     <= b_in[1:D];
            b_sr      <= b_in << D;
            digit_vld <= 1'b1;
            first_dig <= 1'b1;
            busy      <= 1'b1;
            dcnt      <= '0;
            lcnt      <= '0;
            state     <= S_FEED;
          end
        end

        S_FEED: begin
          first_dig <= 1'b0;
          if (abort) begin
            digit     <= '0;
            digit_vld <= 1'b0;
            busy      <= 1'b0;
            dcnt      <= '0;
            state     <= S_IDLE;
          end else if (dcnt == CW'(NDIG - 1)) begin
            digit     <= '0;
            digit_vld <= 1'b0;
            dcnt      <= '0;
            if (LAT == 0) begin
              // No delay line: the product is already valid, so capture now.
              result <= array_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            digit <= b_sr[1:D];
            b_sr  <= b_sr << D;
            dcnt  <= dcnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            lcnt  <= '0;
            state <= S_IDLE;
          end else if (lcnt == LW'(LAT - 1)) begin
            result <= array_res;
            done   <= 1'b1;
            lcnt   <= '0;
            state  <= S_DONE;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end

        default: begin
          // DONE always returns to IDLE; start is ignored for this cycle.
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_dsm_ctrl.sv
// tb_gf_dsm_ctrl: directed bench for gf_dsm_ctrl. An operation-level model
// tracks each accepted request by its cycle offset from the accepting edge
// and predicts every output. The emulated multiplier array drives the golden
// product on array_res only in the cycle where it is valid.
module tb_gf_dsm_ctrl;
  localparam int M       = 16;
  localparam int D       = 4;
  localparam int LAT     = 2;
  localparam int NDIG    = M / D;
  localparam int DONE_PH = NDIG + LAT + 1;

  logic         clk, rst, start, abort;
  logic [1:M]   a_in, b_in, array_res;
  logic         busy, digit_vld, first_dig, done;
  logic [1:M]   a_op, result;
  logic [1:D]   digit;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0;
  int done_q[$];

  gf_dsm_ctrl #(.M(M), .D(D), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .array_res(array_res),
    .busy(busy), .a_op(a_op), .digit(digit), .digit_vld(digit_vld),
    .first_dig(first_dig), .result(result), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // GF(2^16) multiply, polynomial x^16 + x^12 + x^3 + x + 1
  function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 15; i >= 0; i--) begin
      p = p[15] ? ((p << 1) ^ 16'h100B) : (p << 1);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // operation-level model: phase = cycles since the accepting edge
  logic          m_busy;
  int            m_phase;
  logic [M-1:0]  m_a, m_b, m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_phase <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_res   <= '0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        m_busy  <= 1'b1;
        m_phase <= 1;
        m_a     <= a_in;
        m_b     <= b_in;
      end
    end else if (abort || m_phase == DONE_PH) begin
      m_busy <= 1'b0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase + 1 == DONE_PH) m_res <= gf_mul(m_a, m_b);
    end
  end

  // compare process plus emulated array output
  logic         e_vld;
  logic [M-1:0] e_sh;
  logic [D-1:0] e_dig;
  always @(negedge clk) begin
    if (rst) begin
      e_vld = m_busy && m_phase >= 1 && m_phase <= NDIG;
      e_dig = '0;
      if (e_vld) begin
        e_sh  = m_b >> (M - D * m_phase);
        e_dig = e_sh[D-1:0];
      end
      chk("busy", busy, m_busy);
      chk("digit_vld", digit_vld, e_vld);
      chk("digit", digit, e_dig);
      chk("first_dig", first_dig, e_vld && m_phase == 1);
      chk("done", done, m_busy && m_phase == DONE_PH);
      chk("result", result, m_res);
      chk("a_op", a_op, m_a);
      if (done) done_q.push_back(cyc);
    end
    array_res = (m_busy && m_phase == NDIG + LAT) ? gf_mul(m_a, m_b) : 16'($urandom);
  end

  // driver tasks: called at a falling edge, inputs are sampled at the next rising edge
  task automatic launch(input logic [M-1:0] a, input logic [M-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    e0    = cyc;
    @(negedge clk);
    start = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: no done within 40 cycles", nm);
    end
  endtask

  int n0;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    a_in = '0; b_in = '0; array_res = '0;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_a_op", a_op, 0);
    rst = 1'b1;
    @(negedge clk);

    // single op: digits A,5,C,3 then done at E0+7
    launch(16'h1234, 16'hA5C3);
    chk("t2_d0", digit, 4'hA);
    chk("t2_first0", first_dig, 1);
    @(negedge clk);
    chk("t2_d1", digit, 4'h5);
    chk("t2_first1", first_dig, 0);
    @(negedge clk);
    chk("t2_d2", digit, 4'hC);
    @(negedge clk);
    chk("t2_d3", digit, 4'h3);
    @(negedge clk);
    chk("t2_vld_drain", digit_vld, 0);
    @(negedge clk);
    chk("t2_nodone6", done, 0);
    @(negedge clk);
    chk("t2_done7", done, 1);
    chk("t2_lat", cyc - e0, 7);
    @(negedge clk);

    // reset in the middle of FEED
    launch(16'h1234, 16'hA5C3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_vld", digit_vld, 0);
    chk("t1_done", done, 0);
    chk("t1_result", result, 0);
    chk("t1_a_op", a_op, 0);
    chk("t1_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // starts while busy and in the DONE cycle are ignored
    n0 = done_q.size();
    launch(16'h0001, 16'hA5C3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3_a");
    chk("t3_pin_one", result, 16'hA5C3);
    start = 1'b1;
    a_in  = 16'h0002;
    b_in  = 16'h8000;
    @(negedge clk);
    chk("t3_idle_after_done", busy, 0);
    chk("t3_one_done", done_q.size() - n0, 1);
    launch(16'h0002, 16'h8000);
    chk("t3_accepted", busy, 1);
    wait_done("t3_b");
    chk("t3_lat", cyc - e0, 7);
    chk("t3_pin_reduce", result, 16'h100B);
    @(negedge clk);

    // abort at E0+3, restart at E0+5 completes at E0+12
    launch(16'h0001, 16'h5A5A);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_keep", result, 16'h100B);
    n0 = e0;
    @(negedge clk);
    launch(16'hFFFF, 16'hFFFF);
    wait_done("t4");
    chk("t4_done12", cyc - n0, 12);
    @(negedge clk);

    // abort in the last drain cycle beats the capture
    launch(16'h0003, 16'h0007);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_drain_done", done, 0);
    chk("abort_drain_busy", busy, 0);

    // start and abort together in IDLE launch nothing
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    // back-to-back ops, each at the first idle cycle
    done_q.delete();
    for (int i = 0; i < 3; i++) begin
      launch(16'($urandom), 16'($urandom));
      wait_done("t5");
      @(negedge clk);
    end
    chk("t5_count", done_q.size(), 3);
    if (done_q.size() == 3) begin
      chk("t5_gap1", done_q[1] - done_q[0], 8);
      chk("t5_gap2", done_q[2] - done_q[1], 8);
    end

    // boundary operands
    launch(16'h1234, 16'h0000);
    chk("t6_zero_d0", digit, 4'h0);
    chk("t6_zero_vld", digit_vld, 1);
    wait_done("t6_a");
    @(negedge clk);
    launch(16'h1234, 16'hFFFF);
    chk("t6_f_d0", digit, 4'hF);
    repeat (3) @(negedge clk);
    chk("t6_f_d3", digit, 4'hF);
    wait_done("t6_b");
    @(negedge clk);
    launch(16'h0000, 16'hA5C3);
    wait_done("t6_c");
    chk("t6_a_zero", result, 16'h0000);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
